// File: rtl/cpu_pkg.sv
// Types and bus-width defaults shared between the control unit and the
// memory-side responder.
package cpu_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND,
        DONE
    } resp_state_e;

    typedef enum logic {
        READ,
        WRITE
    } bus_req_e;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with registered read (read-before-write);
// contents have no reset.
module sp_ram #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: accepts mem_rd/mem_wr, waits WAIT_STATES cycles,
// answers with a one-cycle ready pulse and holds in DONE until the strobe drops.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_oe,
    output logic                  ready,
    output logic                  fault,
    output logic                  busy
);

    import cpu_pkg::*;

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    resp_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RAM_AW-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    bus_req_e              req_q, req_d;
    logic                  fault_q, fault_d;

    logic                  accept;
    logic                  ram_we;
    logic [RAM_AW-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign accept = (state_q == IDLE) && (mem_rd || mem_wr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = addr[RAM_AW-1:0];
                    wdata_d = data_in;
                    req_d   = mem_wr ? WRITE : READ;
                    fault_d = ({1'b0, addr} >= DEPTH_L) || (mem_rd && mem_wr);
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = RESPOND;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESPOND: state_d = DONE;
            DONE: begin
                if (!mem_rd && !mem_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= READ;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    // Read is launched at accept; afterwards the RAM keeps re-reading the
    // latched address, so rdata stays valid through WAIT into RESPOND.
    assign ram_addr = accept ? addr[RAM_AW-1:0] : addr_q;
    assign ram_we   = (state_q == RESPOND) && (req_q == WRITE) && !fault_q && !rst;

    sp_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign ready    = (state_q == RESPOND);
    assign fault    = ready && fault_q;
    assign data_oe  = ready && (req_q == READ) && !fault_q;
    assign data_out = data_oe ? ram_rdata : '0;
    assign busy     = (state_q != IDLE);

endmodule
